// File: rtl/instruktions_holer.sv
// Instruction fetch stage of the Hans processor: non-pipelined fetch of one
// 32-bit word per instruction, handshake with memory, PC sequencing and jumps.
module instruktions_holer #(
  parameter logic [31:0] START_ADRESSE = 32'h0000_0000
) (
  input  logic        Takt,
  input  logic        Reset,
  output logic        SpeicherAnfrage,
  output logic [31:0] SpeicherAdresse,
  input  logic [31:0] SpeicherDaten,
  input  logic        SpeicherBereit,
  output logic [31:0] Instruktion,
  output logic        DekodierSignal,
  output logic [31:0] BefehlsZaehler,
  input  logic        Weiter,
  input  logic        SprungAktiv,
  input  logic [31:0] SprungZiel,
  output logic [31:0] BefehlsAnzahl
);

  typedef enum logic [1:0] {
    ANFRAGE     = 2'd0,
    AUSGABE     = 2'd1,
    AUSFUEHRUNG = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] bz_q, bz_d;
  logic [31:0] anzahl_q, anzahl_d;
  logic        anfrage_q, anfrage_d;
  logic        dekod_q, dekod_d;

  // Request and strobe are registered from the next state so they line up
  // with the state they belong to; a response is only accepted while the
  // request is actually on the bus (not in the first cycle after reset).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    bz_d      = bz_q;
    anzahl_d  = anzahl_q;
    anfrage_d = 1'b0;
    dekod_d   = 1'b0;
    case (state_q)
      ANFRAGE: begin
        if (anfrage_q && SpeicherBereit) begin
          instr_d = SpeicherDaten;
          bz_d    = pc_q;
          state_d = AUSGABE;
          dekod_d = 1'b1;
        end else begin
          anfrage_d = 1'b1;
        end
      end
      AUSGABE: begin
        anzahl_d = anzahl_q + 32'd1;
        state_d  = AUSFUEHRUNG;
      end
      AUSFUEHRUNG: begin
        if (Weiter) begin
          pc_d      = SprungAktiv ? SprungZiel : pc_q + 32'd1;
          state_d   = ANFRAGE;
          anfrage_d = 1'b1;
        end
      end
      default: begin
        state_d   = ANFRAGE;
        anfrage_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Takt) begin
    if (!Reset) begin
      state_q   <= ANFRAGE;
      pc_q      <= START_ADRESSE;
      instr_q   <= 32'd0;
      bz_q      <= 32'd0;
      anzahl_q  <= 32'd0;
      anfrage_q <= 1'b0;
      dekod_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      bz_q      <= bz_d;
      anzahl_q  <= anzahl_d;
      anfrage_q <= anfrage_d;
      dekod_q   <= dekod_d;
    end
  end

  assign SpeicherAnfrage = anfrage_q;
  assign SpeicherAdresse = pc_q;
  assign Instruktion     = instr_q;
  assign DekodierSignal  = dekod_q;
  assign BefehlsZaehler  = bz_q;
  assign BefehlsAnzahl   = anzahl_q;

endmodule

// File: tb/tb_instruktions_holer.sv
// Directed bench for instruktions_holer: one instance at the default start
// address and one at 32'h100, driven by the same stimulus.
module tb_instruktions_holer;

  logic        Takt = 1'b0;
  logic        Reset;
  logic [31:0] SpeicherDaten;
  logic        SpeicherBereit;
  logic        Weiter;
  logic        SprungAktiv;
  logic [31:0] SprungZiel;

  logic        anf0, dek0, anf1, dek1;
  logic [31:0] adr0, ins0, bz0, anz0, adr1, ins1, bz1, anz1;

  int checks = 0;
  int failures = 0;

  always #5 Takt = ~Takt;

  instruktions_holer dut0 (
    .Takt(Takt), .Reset(Reset),
    .SpeicherAnfrage(anf0), .SpeicherAdresse(adr0),
    .SpeicherDaten(SpeicherDaten), .SpeicherBereit(SpeicherBereit),
    .Instruktion(ins0), .DekodierSignal(dek0), .BefehlsZaehler(bz0),
    .Weiter(Weiter), .SprungAktiv(SprungAktiv), .SprungZiel(SprungZiel),
    .BefehlsAnzahl(anz0)
  );

  instruktions_holer #(.START_ADRESSE(32'h0000_0100)) dut1 (
    .Takt(Takt), .Reset(Reset),
    .SpeicherAnfrage(anf1), .SpeicherAdresse(adr1),
    .SpeicherDaten(SpeicherDaten), .SpeicherBereit(SpeicherBereit),
    .Instruktion(ins1), .DekodierSignal(dek1), .BefehlsZaehler(bz1),
    .Weiter(Weiter), .SprungAktiv(SprungAktiv), .SprungZiel(SprungZiel),
    .BefehlsAnzahl(anz1)
  );

  task automatic tick();
    @(posedge Takt);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0; SpeicherDaten = 32'd0; SpeicherBereit = 1'b0;
    Weiter = 1'b0; SprungAktiv = 1'b0; SprungZiel = 32'd0;
    tick(); tick();
    check("rst_anfrage", {31'd0, anf0}, 32'd0);
    check("rst_dekod",   {31'd0, dek0}, 32'd0);
    check("rst_adresse", adr0, 32'h0);
    check("rst_instr",   ins0, 32'h0);
    check("rst_bz",      bz0, 32'h0);
    check("rst_anzahl",  anz0, 32'h0);
    check("rst_adresse1", adr1, 32'h100);

    // cycle 0: zero-wait fetch of 32'hA000_0001 from address 0
    Reset = 1'b1;
    tick();
    check("c0_anfrage", {31'd0, anf0}, 32'd1);
    check("c0_adresse", adr0, 32'h0);
    check("c0_dekod",   {31'd0, dek0}, 32'd0);
    SpeicherBereit = 1'b1; SpeicherDaten = 32'hA000_0001;
    tick();
    check("c1_dekod",   {31'd0, dek0}, 32'd1);
    check("c1_instr",   ins0, 32'hA000_0001);
    check("c1_bz",      bz0, 32'h0);
    check("c1_anfrage", {31'd0, anf0}, 32'd0);
    check("c1_anzahl",  anz0, 32'd0);
    // Weiter during AUSGABE must be ignored
    SpeicherBereit = 1'b0; Weiter = 1'b1; SprungAktiv = 1'b1; SprungZiel = 32'h55;
    tick();
    check("c2_anzahl", anz0, 32'd1);
    check("c2_dekod",  {31'd0, dek0}, 32'd0);
    // SpeicherBereit during AUSFUEHRUNG must be ignored
    Weiter = 1'b0; SprungAktiv = 1'b0; SpeicherBereit = 1'b1; SpeicherDaten = 32'hDEAD_BEEF;
    tick();
    check("c3_anfrage", {31'd0, anf0}, 32'd0);
    check("c3_dekod",   {31'd0, dek0}, 32'd0);
    check("c3_instr",   ins0, 32'hA000_0001);
    check("c3_adresse", adr0, 32'h0);
    SpeicherBereit = 1'b0;
    tick();
    check("c4_anfrage", {31'd0, anf0}, 32'd0);
    check("c4_adresse", adr0, 32'h0);
    check("c4_anzahl",  anz0, 32'd1);

    // sequential advance, then memory with 3 wait cycles
    Weiter = 1'b1; SprungAktiv = 1'b0;
    tick();
    Weiter = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_anfrage", {31'd0, anf0}, 32'd1);
      check("wait_adresse", adr0, 32'h1);
      check("wait_dekod",   {31'd0, dek0}, 32'd0);
      tick();
    end
    check("wait4_anfrage", {31'd0, anf0}, 32'd1);
    check("wait4_adresse", adr0, 32'h1);
    check("wait4_instr",   ins0, 32'hA000_0001);
    SpeicherBereit = 1'b1; SpeicherDaten = 32'hB000_0002;
    tick();
    check("ws_dekod", {31'd0, dek0}, 32'd1);
    check("ws_instr", ins0, 32'hB000_0002);
    check("ws_bz",    bz0, 32'h1);
    SpeicherBereit = 1'b0;
    tick();
    check("ws_dekod_off", {31'd0, dek0}, 32'd0);
    check("ws_anzahl",    anz0, 32'd2);

    // jump to 32'h40, fetch an all-zero word there
    Weiter = 1'b1; SprungAktiv = 1'b1; SprungZiel = 32'h0000_0040;
    tick();
    check("j40_adresse", adr0, 32'h40);
    check("j40_anfrage", {31'd0, anf0}, 32'd1);
    Weiter = 1'b0; SprungAktiv = 1'b0; SprungZiel = 32'h0;
    SpeicherBereit = 1'b1; SpeicherDaten = 32'h0;
    tick();
    check("j40_dekod", {31'd0, dek0}, 32'd1);
    check("j40_instr", ins0, 32'h0);
    check("j40_bz",    bz0, 32'h40);
    check("j40_adresse_hold", adr0, 32'h40);
    SpeicherBereit = 1'b0;
    tick();
    check("j40_anzahl", anz0, 32'd3);

    // jump to the top address, then PC+1 wraps to 0
    Weiter = 1'b1; SprungAktiv = 1'b1; SprungZiel = 32'hFFFF_FFFF;
    tick();
    check("jtop_adresse", adr0, 32'hFFFF_FFFF);
    Weiter = 1'b0; SprungAktiv = 1'b0;
    SpeicherBereit = 1'b1; SpeicherDaten = 32'hC000_0003;
    tick();
    check("jtop_bz", bz0, 32'hFFFF_FFFF);
    SpeicherBereit = 1'b0;
    tick();
    check("jtop_anzahl", anz0, 32'd4);
    Weiter = 1'b1; SprungAktiv = 1'b0;
    tick();
    check("wrap_adresse", adr0, 32'h0);
    check("wrap_anfrage", {31'd0, anf0}, 32'd1);
    Weiter = 1'b0;

    // reset while a slow memory is still pending
    tick(); tick();
    check("pend_anfrage", {31'd0, anf0}, 32'd1);
    Reset = 1'b0;
    tick();
    check("mr_anfrage",  {31'd0, anf0}, 32'd0);
    check("mr_anzahl",   anz0, 32'd0);
    check("mr_adresse",  adr0, 32'h0);
    check("mr_dekod",    {31'd0, dek0}, 32'd0);
    check("mr_adresse1", adr1, 32'h100);
    check("mr_anzahl1",  anz1, 32'd0);
    Reset = 1'b1;
    tick();
    check("rs_anfrage",  {31'd0, anf0}, 32'd1);
    check("rs_adresse",  adr0, 32'h0);
    check("rs_anfrage1", {31'd0, anf1}, 32'd1);
    check("rs_adresse1", adr1, 32'h100);
    SpeicherBereit = 1'b1; SpeicherDaten = 32'hD000_0004;
    tick();
    check("rs_dekod",  {31'd0, dek0}, 32'd1);
    check("rs_instr",  ins0, 32'hD000_0004);
    check("rs_bz",     bz0, 32'h0);
    check("rs_bz1",    bz1, 32'h100);
    check("rs_instr1", ins1, 32'hD000_0004);
    SpeicherBereit = 1'b0;
    tick();
    check("rs_anzahl", anz0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
